// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified instruction/data memory between two
// requesters: requester 0 is the multi-cycle CPU, requester 1 is the program
// loader / debug port. Each request is one word transfer with a req/ack
// handshake. Ties are broken round-robin.
//
// Each transfer runs IDLE/RESP (grant) -> ACCESS (memory cycle) -> RESP (ack).
// In RESP the other requester can be granted directly, so alternating traffic
// needs no IDLE bubble.
//
// Ports
//   clk, reset            clock (posedge) and asynchronous active-high reset
//   req0/req1             transfer request from CPU / loader
//   we0/we1               1 = write, 0 = read (sampled at grant)
//   addr0/addr1           byte address (sampled at grant)
//   wdata0/wdata1         write data (sampled at grant)
//   ack0/ack1             one-cycle completion pulse
//   rdata0/rdata1         read data, valid with ackN and held until next ackN
//   mem_addr, mem_wdata   to memory Address / Write_data
//   mem_read, mem_write   to memory MemRead / MemWrite
//   mem_rdata             from memory Mem_data (combinational read)
//   busy                  arbiter not idle
//   cnt0/cnt1             completed transfers per requester, wrapping
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic                last;       // requester served most recently
    logic                owner;      // requester of the transfer in flight
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                grant;
    logic                grant_id;

    // State register. The asynchronous clear drops mem_read/mem_write at once,
    // so a write caught mid-ACCESS never reaches the memory.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation ordering cannot change results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, arbitration and output decode. Memory-side outputs depend
    // only on registered state and latched fields, never on req/addr inputs.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_id   = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        busy       = (state != IDLE);

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant      = 1'b1;
                    // Tie goes to whoever was not served last; otherwise the
                    // single requester wins.
                    grant_id   = (req0 && req1) ? ~last : req1;
                    next_state = ACCESS;
                end
            end

            ACCESS: begin
                mem_read   = ~lat_we;
                mem_write  = lat_we;
                next_state = RESP;
            end

            RESP: begin
                ack0 = ~owner;
                ack1 = owner;
                // The owner's req still reflects the finished transfer, so
                // only the other requester can be granted here.
                if (owner ? req0 : req1) begin
                    grant      = 1'b1;
                    grant_id   = ~owner;
                    next_state = ACCESS;
                end else begin
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: request latching, read-data capture, round-robin pointer and
    // completion counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last      <= 1'b1;        // requester 0 wins the first tie
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
            cnt0      <= '0;
            cnt1      <= '0;
        end else begin
            if (grant) begin
                owner     <= grant_id;
                lat_we    <= grant_id ? we1    : we0;
                lat_addr  <= grant_id ? addr1  : addr0;
                lat_wdata <= grant_id ? wdata1 : wdata0;
            end

            if (state == ACCESS && !lat_we) begin
                if (owner) begin
                    rdata1 <= mem_rdata;
                end else begin
                    rdata0 <= mem_rdata;
                end
            end

            if (state == RESP) begin
                last <= owner;
                if (owner) begin
                    cnt1 <= cnt1 + 1'b1;
                end else begin
                    cnt0 <= cnt0 + 1'b1;
                end
            end
        end
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with a small word-addressed memory
// model (combinational read, write on posedge). Inputs are driven and outputs
// sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              reset;
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read, mem_write;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic [CNT_W-1:0]  cnt0, cnt1;

    int vectors;
    int miscompares;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    // Memory model: 64 words, byte address bits [7:2] select the word.
    logic [DATA_W-1:0] mem [0:63];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 32'h3C04ABCD;              // lui $a0, 0xABCD
    end

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset  = 1'b1;
        req0   = 1'b0; req1   = 1'b0;
        we0    = 1'b0; we1    = 1'b0;
        addr0  = '0;   addr1  = '0;
        wdata0 = '0;   wdata1 = '0;

        // ---- reset state ----
        step();
        step();
        check("rst_ack0",  ack0,      1'b0);
        check("rst_ack1",  ack1,      1'b0);
        check("rst_busy",  busy,      1'b0);
        check("rst_mread", mem_read,  1'b0);
        check("rst_mwrite",mem_write, 1'b0);
        check("rst_maddr", mem_addr,  32'h0);
        check("rst_rdata0",rdata0,    32'h0);
        check("rst_cnt0",  cnt0,      16'h0);
        check("rst_cnt1",  cnt1,      16'h0);
        reset = 1'b0;

        // ---- 1: CPU read of word 0 ----
        step();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
        step();                                   // ACCESS
        check("t1_mread",  mem_read,  1'b1);
        check("t1_mwrite", mem_write, 1'b0);
        check("t1_maddr",  mem_addr,  32'h0);
        check("t1_busy",   busy,      1'b1);
        check("t1_ack0_c1",ack0,      1'b0);
        req0 = 1'b0;
        step();                                   // RESP
        check("t1_ack0",   ack0,      1'b1);
        check("t1_ack1",   ack1,      1'b0);
        check("t1_rdata0", rdata0,    32'h3C04ABCD);
        check("t1_mread_r",mem_read,  1'b0);
        step();                                   // IDLE
        check("t1_ack0_off",ack0,     1'b0);
        check("t1_busy_off",busy,     1'b0);
        check("t1_cnt0",   cnt0,      16'h1);

        // ---- 2: loader write 0x80, then CPU read of 0x80 ----
        do_reset();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h80; wdata1 = 32'hDEADBEEF;
        step();                                   // ACCESS (owner 1)
        check("t2_mwrite", mem_write, 1'b1);
        check("t2_maddr",  mem_addr,  32'h80);
        check("t2_mwdata", mem_wdata, 32'hDEADBEEF);
        req1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;  // post-grant changes ignored
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h80;
        step();                                   // RESP (owner 1), grants 0
        check("t2_ack1",   ack1,      1'b1);
        check("t2_ack0_no",ack0,      1'b0);
        check("t2_mwrite_r",mem_write,1'b0);
        step();                                   // ACCESS (owner 0)
        check("t2_busy",   busy,      1'b1);
        check("t2_mread",  mem_read,  1'b1);
        check("t2_maddr2", mem_addr,  32'h80);
        req0 = 1'b0;
        step();                                   // RESP (owner 0)
        check("t2_ack0",   ack0,      1'b1);
        check("t2_rdata0", rdata0,    32'hDEADBEEF);
        step();
        check("t2_cnt0",   cnt0,      16'h1);
        check("t2_cnt1",   cnt1,      16'h1);

        // ---- 3: both requesters held, grants alternate 0,1,0,1 ----
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h80;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("t3_ack0", ack0, (k % 4 == 2));
            check("t3_ack1", ack1, (k % 4 == 0));
            check("t3_both", ack0 & ack1, 1'b0);
            check("t3_busy", busy, 1'b1);
            if (k % 2 == 1) check("t3_maddr", mem_addr, (k % 4 == 1) ? 32'h0 : 32'h80);
            if (k == 4) check("t3_rdata1", rdata1, 32'hDEADBEEF);
            if (k == 8) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        step();
        check("t3_cnt0", cnt0, 16'h2);
        check("t3_cnt1", cnt1, 16'h2);
        check("t3_idle", busy, 1'b0);

        // ---- 4: single requester, one transfer per 3 cycles ----
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("t4_ack0", ack0, (k % 3 == 2));
            check("t4_busy", busy, (k % 3 != 0));
            if (k == 11) req0 = 1'b0;
        end
        check("t4_cnt0", cnt0, 16'h4);

        // ---- 5: reset in the middle of a write ----
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h84; wdata0 = 32'h12345678;
        step();                                   // ACCESS
        check("t5_mwrite_on", mem_write, 1'b1);
        req0 = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t5_mwrite_off", mem_write, 1'b0);
        check("t5_mread_off",  mem_read,  1'b0);
        check("t5_busy_off",   busy,      1'b0);
        step();
        check("t5_no_ack",     ack0,      1'b0);
        step();
        reset = 1'b0;
        check("t5_mem_model",  mem[33],   32'h0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h84;
        step();
        req0 = 1'b0;
        step();
        check("t5_ack0",   ack0,   1'b1);
        check("t5_rdata0", rdata0, 32'h0);
        step();

        // ---- 6: counter wrap ----
        force dut.cnt1 = 16'hFFFF;
        step();
        release dut.cnt1;
        check("t6_cnt1_pre", cnt1, 16'hFFFF);
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0;
        step();
        req1 = 1'b0;
        step();
        check("t6_ack1",   ack1,   1'b1);
        check("t6_rdata1", rdata1, 32'h3C04ABCD);
        step();
        check("t6_cnt1_wrap", cnt1, 16'h0);
        check("t6_cnt0",      cnt0, 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
